led_sequence_controller: RTL and testbench
==========================================

Name: led_sequence_controller

Overview:
- Sequences the board LEDs from one clock: a free-running prescaler generates a millisecond tick, and a mode FSM steps the LED patterns on that tick.
- Replaces the ad-hoc per-design blink counter. Top-level logic configures mode and timing, then issues start/stop strobes.
- Sits between the top-level control logic and the LED pins.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1000, tick rate in Hz. TICK_DIV = CLK_HZ/TICK_HZ; CLK_HZ must be an exact multiple of TICK_HZ.
- HP_W, 16, width of the half-period field, in ticks.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle strobe: latch config and begin sequencing.
- stop  in  1  one-cycle strobe: return to IDLE.
- mode  in  2  0=SOLID, 1=BLINK, 2=BURST, 3=SYNC.
- half_period  in  HP_W  phase length in ticks; 0 is treated as 1.
- burst_count  in  4  ON pulses per burst; 0 is treated as 1.
- LED  out  2  LED drive.
- busy  out  1  high in any state other than IDLE.
- tick  out  1  one-cycle prescaler pulse, for debug and verification.

Behaviour:
- Reset (async assert, sync release): state=IDLE, LED=2'b00, busy=0, tick=0, prescaler=0, all counters=0.
- All outputs are registered. A new state is visible on LED the cycle after the edge that enters it.

Prescaler:
- Counts 0..TICK_DIV-1 and wraps.
- tick=1 for exactly the cycle in which the count equals TICK_DIV-1.
- Cleared to 0 on every accepted start, so the first tick arrives TICK_DIV cycles after the start edge.

Config latch:
- mode, half_period and burst_count are captured on an accepted start.
- Changes to these inputs while busy have no effect.

FSM states and transitions:
- IDLE, RUN_ON, RUN_OFF, PAUSE.
- IDLE -> RUN_ON on start.
- RUN_ON -> RUN_OFF after hp ticks, where hp = max(half_period, 1). Exception: SOLID stays in RUN_ON indefinitely.
- RUN_OFF -> RUN_ON after hp ticks. Exception: in BURST, when the pulse counter reaches bc = max(burst_count, 1), RUN_OFF -> PAUSE instead.
- PAUSE -> RUN_ON after 4*hp ticks; the pulse counter is cleared. The counter is HP_W+2 bits wide and must not overflow.
- Phase tick counter: counts ticks within a phase and clears on every state change. The transition happens on the clock edge where tick=1 and the count reaches the phase length minus 1.

LED patterns (ON / OFF and PAUSE):
- SOLID: 01 / not applicable.
- BLINK: 01 / 10.
- BURST: 11 / 00.
- SYNC: 11 / 00.
- IDLE: 00.

Boundary conditions:
- start and stop in the same cycle: stop wins; go to or stay in IDLE.
- start while busy: restart. Re-latch config, clear the prescaler and all counters, enter RUN_ON.
- stop while IDLE: no effect.
- Reset asserted mid-sequence: immediately to the reset values, with no wait for a clock edge.
- half_period at its maximum (all ones): no wrap. The phase lasts exactly 2^HP_W - 1 ticks.

Decomposition:
- Shared package led_seq_pkg:
  - mode encodings: MODE_SOLID, MODE_BLINK, MODE_BURST, MODE_SYNC.
  - FSM state encoding.
  - LED pattern constants: LED_OFF=00, LED_A=01, LED_B=10, LED_ALL=11.
  - PAUSE_MULT=4.
- One sub-module, tick_prescaler: parameters CLK_HZ and TICK_HZ; ports clock, reset, clear, tick. It is reused by other timed blocks in the codebase.

Test Plan (CLK_HZ=1000, TICK_HZ=100, so TICK_DIV=10):
- Reset, then idle for 50 cycles -> LED=00, busy=0. tick pulses every 10 cycles: the first at cycle 9, then 19, 29.
- BLINK: mode=1, hp=3, start -> LED=01 for exactly 30 cycles, then 10 for 30 cycles, repeating; busy=1 throughout.
- BURST: mode=2, hp=2, bc=3 -> three cycles of (11 for 20 cycles, 00 for 20 cycles), then 00 for 80 cycles of PAUSE, then 11 again.
- SOLID: mode=0, start -> LED=01 held for 500 cycles. Then start and stop asserted in the same cycle -> LED=00, busy=0 on the next cycle.
- Restart: BLINK hp=5, start; at cycle 17 pulse start with mode=3, hp=1 -> LED=11 from cycle 18, toggling every 10 cycles. Changing the mode input later has no effect.
- Async reset: assert RESET_N=0 mid-BURST, between clock edges -> LED=00 and busy=0 without waiting for a clock edge. After release, start is required before any activity.

Source files
------------

// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
//   Shared definitions for the LED sequencer: mode and FSM state encodings,
//   LED drive patterns, the pause length multiplier, and a helper that maps a
//   (state, mode) pair to the LED pattern driven in that state.
// -----------------------------------------------------------------------------
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_BURST = 2'd2,
        MODE_SYNC  = 2'd3
    } led_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN_ON  = 2'd1,
        ST_RUN_OFF = 2'd2,
        ST_PAUSE   = 2'd3
    } led_state_t;

    localparam logic [1:0] LED_OFF = 2'b00;
    localparam logic [1:0] LED_A   = 2'b01;
    localparam logic [1:0] LED_B   = 2'b10;
    localparam logic [1:0] LED_ALL = 2'b11;

    // PAUSE lasts this many half-periods
    localparam int unsigned PAUSE_MULT = 4;

    // LED drive for a given state under a given mode. PAUSE and IDLE are dark;
    // only BLINK lights anything during the OFF phase.
    function automatic logic [1:0] led_pattern(input led_state_t st,
                                               input led_mode_t  md);
        logic [1:0] pat;
        pat = LED_OFF;
        case (st)
            ST_RUN_ON: begin
                if (md == MODE_SOLID || md == MODE_BLINK)
                    pat = LED_A;
                else
                    pat = LED_ALL;
            end
            ST_RUN_OFF: begin
                if (md == MODE_BLINK)
                    pat = LED_B;
                else
                    pat = LED_OFF;
            end
            default: pat = LED_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_sequence_controller_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Free-running divider producing a one-cycle tick every CLK_HZ/TICK_HZ
//   clocks. The count runs 0..TICK_DIV-1 and wraps; the tick is high for the
//   whole cycle in which the count equals TICK_DIV-1. A clear restarts the
//   count at 0, so the next tick is seen TICK_DIV-1 cycles after the clearing
//   edge and consumed on the TICK_DIV-th edge.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_clear  : synchronous restart of the count
//   o_tick   : registered one-cycle tick
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_tick;

    always_comb begin
        w_cnt_next = r_cnt + 1'b1;
        if (i_clear || r_cnt == LAST)
            w_cnt_next = '0;
    end

    // The tick is registered from the next count so it coincides exactly with
    // the cycle in which the count sits at its last value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= (w_cnt_next == LAST);
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/led_sequence_controller.sv
// -----------------------------------------------------------------------------
// led_sequence_controller
//   Drives two board LEDs through SOLID / BLINK / BURST / SYNC patterns. A
//   tick_prescaler supplies the time base; a four-state FSM
//   (IDLE, RUN_ON, RUN_OFF, PAUSE) advances on ticks. Configuration is
//   latched on an accepted start and ignored while busy.
//
// Ports
//   CLOCK_50    : system clock, rising edge
//   RESET_N     : asynchronous active-low reset
//   start       : one-cycle strobe, latch config and (re)start sequencing
//   stop        : one-cycle strobe, return to IDLE (wins over start)
//   mode        : 0 SOLID, 1 BLINK, 2 BURST, 3 SYNC
//   half_period : phase length in ticks, 0 treated as 1
//   burst_count : ON pulses per burst, 0 treated as 1
//   LED         : registered LED drive
//   busy        : registered, high whenever not IDLE
//   tick        : registered prescaler pulse
// -----------------------------------------------------------------------------
module led_sequence_controller
    import led_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned HP_W    = 16
) (
    input  logic            CLOCK_50,
    input  logic            RESET_N,
    input  logic            start,
    input  logic            stop,
    input  logic [1:0]      mode,
    input  logic [HP_W-1:0] half_period,
    input  logic [3:0]      burst_count,
    output logic [1:0]      LED,
    output logic            busy,
    output logic            tick
);

    // Phase counter is two bits wider than the half period so the PAUSE
    // length (4 * hp) cannot overflow even at hp = all ones.
    localparam int unsigned PC_W = HP_W + 2;

    led_state_t      r_state;
    led_state_t      w_state_next;

    led_mode_t       r_mode;
    logic [HP_W-1:0] r_hp;
    logic [3:0]      r_bc;
    logic [3:0]      r_pulse_cnt;
    logic [PC_W-1:0] r_phase_cnt;
    logic [1:0]      r_led;
    logic            r_busy;

    logic            w_restart;
    logic            w_tick;
    logic            w_phase_done;
    logic [PC_W-1:0] w_phase_len;
    led_mode_t       w_mode_eff;
    logic [1:0]      w_led_next;
    logic            w_busy_next;

    // stop takes priority, so a simultaneous start is not an accepted start
    assign w_restart = start && !stop;

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_prescaler (
        .i_clk   (CLOCK_50),
        .i_rst_n (RESET_N),
        .i_clear (w_restart),
        .o_tick  (w_tick)
    );

    // Phase length in ticks for the current state
    always_comb begin
        w_phase_len = PC_W'(r_hp);
        if (r_state == ST_PAUSE)
            w_phase_len = PC_W'(r_hp) * PC_W'(PAUSE_MULT);
    end

    assign w_phase_done = w_tick && (r_phase_cnt == w_phase_len - PC_W'(1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        if (stop) begin
            w_state_next = ST_IDLE;
        end else if (start) begin
            w_state_next = ST_RUN_ON;
        end else if (w_phase_done) begin
            case (r_state)
                ST_RUN_ON: begin
                    if (r_mode != MODE_SOLID)
                        w_state_next = ST_RUN_OFF;
                end
                ST_RUN_OFF: begin
                    if (r_mode == MODE_BURST && r_pulse_cnt >= r_bc)
                        w_state_next = ST_PAUSE;
                    else
                        w_state_next = ST_RUN_ON;
                end
                ST_PAUSE: w_state_next = ST_RUN_ON;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: output logic ----------------
    // Outputs are decoded from the next state and registered, so LED and
    // busy change on the same edge that enters the new state. On a restart
    // the freshly presented mode applies rather than the stale latched one.
    always_comb begin
        w_mode_eff  = w_restart ? led_mode_t'(mode) : r_mode;
        w_led_next  = led_pattern(w_state_next, w_mode_eff);
        w_busy_next = (w_state_next != ST_IDLE);
    end

    // ---------------- config latch, counters, output registers ----------------
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mode      <= MODE_SOLID;
            r_hp        <= '0;
            r_bc        <= '0;
            r_pulse_cnt <= '0;
            r_phase_cnt <= '0;
            r_led       <= LED_OFF;
            r_busy      <= 1'b0;
        end else begin
            r_led  <= w_led_next;
            r_busy <= w_busy_next;

            if (w_restart) begin
                r_mode <= led_mode_t'(mode);
                r_hp   <= (half_period == '0) ? HP_W'(1) : half_period;
                r_bc   <= (burst_count == '0) ? 4'd1 : burst_count;
            end

            // Clearing on phase_done as well keeps SOLID's endless RUN_ON
            // phase from letting the counter run away.
            if (w_restart || r_state == ST_IDLE || w_state_next != r_state || w_phase_done)
                r_phase_cnt <= '0;
            else if (w_tick)
                r_phase_cnt <= r_phase_cnt + 1'b1;

            // Pulses are counted at the end of each BURST ON phase, so by the
            // end of the following OFF phase the count equals pulses emitted.
            if (w_restart || w_state_next == ST_IDLE)
                r_pulse_cnt <= '0;
            else if (r_state == ST_PAUSE && w_state_next == ST_RUN_ON)
                r_pulse_cnt <= '0;
            else if (r_state == ST_RUN_ON && w_state_next == ST_RUN_OFF && r_mode == MODE_BURST)
                r_pulse_cnt <= r_pulse_cnt + 1'b1;
        end
    end

    assign LED  = r_led;
    assign busy = r_busy;
    assign tick = w_tick;

endmodule

// File: tb/tb_led_sequence_controller.sv
// -----------------------------------------------------------------------------
// tb_led_sequence_controller
//   Scoreboard bench. After every clock edge the driver advances a timeline
//   model (cycles since start, cycles since prescaler clear) and queues the
//   expected LED/busy/tick; a monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_led_sequence_controller;

    localparam int unsigned D   = 10;   // CLK_HZ / TICK_HZ
    localparam int unsigned HPW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           stop;
    logic [1:0]     mode;
    logic [HPW-1:0] hp;
    logic [3:0]     bc;
    logic [1:0]     led;
    logic           busy;
    logic           tick;

    always #5 clk = ~clk;

    led_sequence_controller #(
        .CLK_HZ  (1000),
        .TICK_HZ (100),
        .HP_W    (HPW)
    ) dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .half_period (hp),
        .burst_count (bc),
        .LED         (led),
        .busy        (busy),
        .tick        (tick)
    );

    typedef struct packed {
        logic [1:0] led;
        logic       busy;
        logic       tick;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state: whether running, latched config, cycles since the
    // start edge, cycles since the last prescaler clear (mod D).
    bit m_run = 0;
    int m_mode = 0, m_hp = 1, m_bc = 1, m_t = 0, m_pc = 0;

    // LED as a pure function of elapsed cycles since start.
    function automatic logic [1:0] ref_led(int md, int h, int b, int t);
        int L, per, r;
        L = h * D;
        case (md)
            0: return 2'b01;
            1: return ((t / L) % 2 == 0) ? 2'b01 : 2'b10;
            3: return ((t / L) % 2 == 0) ? 2'b11 : 2'b00;
            default: begin
                per = 2 * b * L + 4 * L;
                r   = t % per;
                if (r < 2 * b * L && (r / L) % 2 == 0)
                    return 2'b11;
                return 2'b00;
            end
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.led  = m_run ? ref_led(m_mode, m_hp, m_bc, m_t) : 2'b00;
        e.busy = m_run;
        e.tick = (m_pc == D - 1);
        return e;
    endfunction

    // Effect of the clock edge just passed, given the inputs held across it.
    task automatic model_edge();
        if (!rst_n) begin
            m_run = 0;
            m_pc  = 0;
        end else if (stop) begin
            m_run = 0;
            m_pc  = (m_pc + 1) % D;
        end else if (start) begin
            m_run  = 1;
            m_t    = 0;
            m_pc   = 0;
            m_mode = int'(mode);
            m_hp   = (hp == 0) ? 1 : int'(hp);
            m_bc   = (bc == 0) ? 1 : int'(bc);
        end else begin
            m_pc = (m_pc + 1) % D;
            if (m_run)
                m_t = m_t + 1;
        end
    endtask

    // One clock: present inputs, let the edge happen, queue the expectation.
    task automatic cyc(input bit st, input bit sp, input bit noise);
        start = st;
        stop  = sp;
        if (noise && !st) begin
            mode = 2'($urandom_range(0, 3));
            hp   = HPW'($urandom_range(0, 15));
            bc   = 4'($urandom_range(0, 15));
        end
        @(posedge clk);
        #1;
        model_edge();
        sb_q.push_back(model_out());
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic go(input int md, input int h, input int b);
        mode = 2'(md);
        hp   = HPW'(h);
        bc   = 4'(b);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b1);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset_mid();
        #2;
        rst_n = 1'b0;
        m_run = 0;
        m_pc  = 0;
        void'(sb_q.pop_back());
        sb_q.push_back(model_out());
        #1;
        n_checks++;
        if (led == 2'b00 && busy == 1'b0 && tick == 1'b0)
            n_pass++;
        else
            $display("FAIL async_reset LED=%b busy=%b tick=%b required LED=00 busy=0 tick=0",
                     led, busy, tick);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
    endtask

    // Monitor: every falling edge the DUT presents a fresh registered output.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (led === e.led && busy === e.busy && tick === e.tick)
                n_pass++;
            else
                $display("FAIL outputs t=%0t LED=%b busy=%b tick=%b required LED=%b busy=%b tick=%b",
                         $time, led, busy, tick, e.led, e.busy, e.tick);
        end
    end

    initial begin
        int r;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        mode  = '0;
        hp    = '0;
        bc    = '0;
        #1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // idle: no LED, tick every 10 cycles; stop while idle is harmless
        run(25);
        cyc(1'b0, 1'b1, 1'b0);
        run(24);

        // BLINK hp=3
        go(1, 3, 0);
        run(150);

        // BURST hp=2 bc=3, past one full burst plus pause into the next
        go(2, 2, 3);
        run(330);

        // SOLID, then simultaneous start+stop
        go(0, 3, 0);
        run(500);
        cyc(1'b1, 1'b1, 1'b0);
        run(20);

        // restart: BLINK hp=5, then SYNC hp=1 at cycle 17
        go(1, 5, 0);
        run(16);
        go(3, 1, 0);
        run(60);

        // half_period at maximum and zero, burst_count zero
        go(1, 15, 0);
        run(320);
        go(2, 0, 0);
        run(80);
        go(2, 15, 1);
        run(950);

        // async reset mid-BURST, then idle until a fresh start
        go(2, 1, 2);
        run(37);
        async_reset_mid();
        run(30);

        // randomized sequences
        for (int it = 0; it < 40; it++) begin
            go($urandom_range(0, 3),
               ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 4),
               $urandom_range(0, 5));
            for (int c = 0; c < int'($urandom_range(20, 300)); c++) begin
                r = $urandom_range(0, 99);
                if (r == 0)
                    cyc(1'b0, 1'b1, 1'b1);
                else if (r == 1)
                    cyc(1'b1, 1'b1, 1'b1);
                else if (r == 2)
                    go($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 5));
                else
                    cyc(1'b0, 1'b0, 1'b1);
            end
            if ($urandom_range(0, 9) == 0)
                async_reset_mid();
        end

        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0)
            n_pass++;
        else
            $display("FAIL drain pending=%0d required 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
